// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared types and constants for the period meter.
// Optional build macro used by this block: PERIOD_METER_SYNC_EN.
package period_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int DEF_W         = 10;
    localparam int DEF_MIN_EDGES = 2;

    // Full-scale counter value for a w-bit period counter (2^w - 1).
    function automatic longint unsigned sat_value(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/period_meter_if.sv
// period_meter_if: strobe input, enable and measurement results of the period meter.
// The master side drives EN/PULSE, the slave side (the meter) returns the results.
interface period_meter_if
    import period_meter_pkg::*;
#(
    parameter int W = DEF_W
);
    logic         EN;
    logic         PULSE;
    logic [W-1:0] PERIOD;
    logic         VALID;
    logic         OVF;
    logic         LOCKED;

    modport master (
        output EN,
        output PULSE,
        input  PERIOD,
        input  VALID,
        input  OVF,
        input  LOCKED
    );

    modport slave (
        input  EN,
        input  PULSE,
        output PERIOD,
        output VALID,
        output OVF,
        output LOCKED
    );
endinterface

// File: rtl/pulse_edge_det.sv
// pulse_edge_det: rising-edge detector for the measured strobe.
// With PERIOD_METER_SYNC_EN defined the strobe first passes a 2-flop synchronizer.
// All flops reset to 1 so a strobe held high through reset is not an edge.
module pulse_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    output logic rise
);
    logic pulse_s;
    logic pulse_d;

`ifdef PERIOD_METER_SYNC_EN
    logic sync1;
    logic sync2;

    // Two-stage synchronizer bringing an asynchronous strobe into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pulse;
            sync2 <= sync1;
        end
    end

    assign pulse_s = sync2;
`else
    assign pulse_s = pulse;
`endif

    // Previous-cycle copy of the strobe; updates every cycle regardless of enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_d <= 1'b1;
        end else begin
            pulse_d <= pulse_s;
        end
    end

    assign rise = pulse_s & ~pulse_d;

endmodule

// File: rtl/period_meter.sv
// period_meter: counts enabled clock cycles between consecutive rising edges of PULSE
// and publishes each period with a one-cycle VALID strobe, an overflow flag and LOCKED.
// Optional build macro: PERIOD_METER_SYNC_EN (adds a 2-flop input synchronizer).
module period_meter
    import period_meter_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int MIN_EDGES = DEF_MIN_EDGES
) (
    input  logic           CLOCK,
    input  logic           RESET,
    period_meter_if.slave  bus
);
    localparam logic [W-1:0] SAT = W'(sat_value(W));
    localparam int           ECW = $clog2(MIN_EDGES + 1);

    logic           rise;
    logic           accept;
    state_t         state;
    state_t         state_n;
    logic [W-1:0]   cnt;
    logic [W-1:0]   cnt_n;
    logic           capture;
    logic [W-1:0]   period;
    logic           ovf;
    logic           valid;
    logic           locked;
    logic [ECW-1:0] edge_cnt;

    pulse_edge_det u_edge_det (
        .clk   (CLOCK),
        .rst   (RESET),
        .pulse (bus.PULSE),
        .rise  (rise)
    );

    // An edge only counts when enable is high in the same cycle; otherwise it is lost.
    assign accept = rise & bus.EN;

    // State register.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, next count and capture decision; with enable low everything holds.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        if (accept) begin
            cnt_n = W'(1);
            if (state == IDLE) begin
                state_n = MEASURE;
            end else begin
                capture = 1'b1;
            end
        end else if (bus.EN && (state == MEASURE) && (cnt != SAT)) begin
            cnt_n = cnt + W'(1);
        end
    end

    // Period counter, captured result and the registered VALID strobe.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cnt    <= '0;
            period <= '0;
            ovf    <= 1'b0;
            valid  <= 1'b0;
        end else begin
            cnt   <= cnt_n;
            valid <= capture;
            if (capture) begin
                period <= cnt;
                ovf    <= (cnt == SAT);
            end
        end
    end

    // Saturating accepted-edge count and the sticky LOCKED flag.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            edge_cnt <= '0;
            locked   <= 1'b0;
        end else if (accept) begin
            if (edge_cnt != ECW'(MIN_EDGES)) begin
                edge_cnt <= edge_cnt + ECW'(1);
            end
            if (edge_cnt == ECW'(MIN_EDGES - 1)) begin
                locked <= 1'b1;
            end
        end
    end

    assign bus.PERIOD = period;
    assign bus.VALID  = valid;
    assign bus.OVF    = ovf;
    assign bus.LOCKED = locked;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed, table-driven bench for period_meter (W=10, MIN_EDGES=2).
// Build with PERIOD_METER_SYNC_EN defined to exercise the synchronized input path.
module tb_period_meter;

    localparam int W = 10;

`ifdef PERIOD_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic         rst;
        logic         en;
        logic         pulse;
        logic         exp_valid;
        logic [W-1:0] exp_period;
        logic         exp_ovf;
        logic         exp_locked;
    } vec_t;

    logic clock;
    logic reset;
    int   errors;
    int   checks;
    int   quiet_bad;

    period_meter_if #(.W(W)) bus ();

    period_meter #(.W(W), .MIN_EDGES(2)) dut (
        .CLOCK (clock),
        .RESET (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one cycle of inputs and return after the following posedge (at negedge).
    task automatic applyStimulus(input logic r, input logic e, input logic p);
        reset     = r;
        bus.EN    = e;
        bus.PULSE = p;
        @(negedge clock);
    endtask

    task automatic checkOutput(input string name, input logic v, input logic [W-1:0] per,
                               input logic o, input logic l);
        checks++;
        if (bus.VALID !== v || bus.PERIOD !== per || bus.OVF !== o || bus.LOCKED !== l) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%b period=%0d ovf=%b locked=%b, expected valid=%b period=%0d ovf=%b locked=%b",
                     name, bus.VALID, bus.PERIOD, bus.OVF, bus.LOCKED, v, per, o, l);
        end
    endtask

    task automatic checkQuiet(input string name);
        checks++;
        if (quiet_bad != 0) begin
            errors++;
            $display("[TB] FAIL %s: got %0d unexpected VALID cycles, expected 0", name, quiet_bad);
        end
        quiet_bad = 0;
    endtask

    // n cycles with PULSE low; any VALID seen here is unexpected.
    task automatic gap(input int n, input logic e);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, e, 1'b0);
            if (bus.VALID !== 1'b0) quiet_bad++;
        end
    endtask

    // One-cycle edge followed by the detection latency, then check the published result.
    task automatic edgeCheck(input string name, input logic [W-1:0] per, input logic o,
                             input logic v, input logic l);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < LAT; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput(name, v, per, o, l);
    endtask

    vec_t vecs [19];

    task automatic setVec(input int i, input logic r, input logic e, input logic p,
                          input logic v, input logic [W-1:0] per, input logic o, input logic l);
        vecs[i].rst        = r;
        vecs[i].en         = e;
        vecs[i].pulse      = p;
        vecs[i].exp_valid  = v;
        vecs[i].exp_period = per;
        vecs[i].exp_ovf    = o;
        vecs[i].exp_locked = l;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        quiet_bad = 0;
        reset     = 1'b1;
        bus.EN    = 1'b0;
        bus.PULSE = 1'b1;

        // reset with PULSE high, release, minimum period, lost edge, reset mid-interval
        setVec(0,  1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
        setVec(1,  1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
        setVec(2,  1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
        setVec(3,  1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
        setVec(4,  1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
        setVec(5,  1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
        setVec(6,  1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
        setVec(7,  1'b0, 1'b1, 1'b1, 1'b1, 10'd2, 1'b0, 1'b1);
        setVec(8,  1'b0, 1'b1, 1'b0, 1'b0, 10'd2, 1'b0, 1'b1);
        setVec(9,  1'b0, 1'b1, 1'b1, 1'b1, 10'd2, 1'b0, 1'b1);
        setVec(10, 1'b0, 1'b1, 1'b0, 1'b0, 10'd2, 1'b0, 1'b1);
        setVec(11, 1'b0, 1'b0, 1'b1, 1'b0, 10'd2, 1'b0, 1'b1);
        setVec(12, 1'b0, 1'b1, 1'b1, 1'b0, 10'd2, 1'b0, 1'b1);
        setVec(13, 1'b0, 1'b1, 1'b0, 1'b0, 10'd2, 1'b0, 1'b1);
        setVec(14, 1'b0, 1'b1, 1'b1, 1'b1, 10'd4, 1'b0, 1'b1);
        setVec(15, 1'b0, 1'b1, 1'b0, 1'b0, 10'd4, 1'b0, 1'b1);
        setVec(16, 1'b0, 1'b1, 1'b0, 1'b0, 10'd4, 1'b0, 1'b1);
        setVec(17, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
        setVec(18, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);

`ifndef PERIOD_METER_SYNC_EN
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].pulse);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_period,
                        vecs[i].exp_ovf, vecs[i].exp_locked);
        end
`endif

        // Reset with PULSE held high across release: must not count as an edge.
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("reset_state", 1'b0, 10'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (bus.VALID !== 1'b0) quiet_bad++;
        end
        gap(5, 1'b1);
        edgeCheck("first_edge", 10'd0, 1'b0, 1'b0, 1'b0);
        gap(100, 1'b1);
        checkQuiet("held_pulse_no_edge");

        // Reset mid-interval, then edges 300 apart.
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("reset_mid", 1'b0, 10'd0, 1'b0, 1'b0);
        gap(3, 1'b1);
        edgeCheck("edge_after_reset", 10'd0, 1'b0, 1'b0, 1'b0);
        gap(299 - LAT, 1'b1);
        edgeCheck("period_300", 10'd300, 1'b0, 1'b1, 1'b1);

        // Divider loopback at 1/1000.
        for (int k = 0; k < 3; k++) begin
            gap(999 - LAT, 1'b1);
            edgeCheck($sformatf("div1000_%0d", k), 10'd1000, 1'b0, 1'b1, 1'b1);
        end

        // Saturation boundaries and OVF clearing.
        gap(1499 - LAT, 1'b1);
        edgeCheck("sat_1500", 10'd1023, 1'b1, 1'b1, 1'b1);
        gap(399 - LAT, 1'b1);
        edgeCheck("after_sat_400", 10'd400, 1'b0, 1'b1, 1'b1);
        gap(1022 - LAT, 1'b1);
        edgeCheck("exact_1023", 10'd1023, 1'b1, 1'b1, 1'b1);
        gap(1021 - LAT, 1'b1);
        edgeCheck("below_sat_1022", 10'd1022, 1'b0, 1'b1, 1'b1);
        checkQuiet("quiet_intervals");

        // EN gating: 50 disabled cycles mid-interval, with a lost edge inside them.
        gap(49 - LAT, 1'b1);
        gap(24, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        if (bus.VALID !== 1'b0) quiet_bad++;
        gap(25, 1'b0);
        checkQuiet("en_low_edge_ignored");
        gap(50, 1'b1);
        edgeCheck("en_gated_100", 10'd100, 1'b0, 1'b1, 1'b1);
        gap(3, 1'b1);
        checkQuiet("valid_one_cycle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Receive-side counterpart of the team's 1/N frequency divider.
- Measures the number of enabled CLOCK cycles between consecutive rising edges on a strobe input, e.g. a divider CY output or an external tick.
- Publishes each measured period with a one-cycle VALID strobe and an overflow flag.
- Used in the final design to self-check divider outputs and to measure external event rates.

Parameters:
- W, 10, width of the period counter and PERIOD output; full-scale value is 2^W-1 (1023 at default).
- MIN_EDGES, 2, number of accepted edges before LOCKED asserts (≥2).

Ports:
- CLOCK   input   1  system clock; all logic on posedge.
- RESET   input   1  synchronous, active-high reset.
- EN      input   1  count/accept enable; when low, the counter holds and edges are ignored.
- PULSE   input   1  measured strobe, level or pulse; rising edge is the event.
- PERIOD  output  W  last measured period, in enabled cycles.
- VALID   output  1  one-cycle strobe; PERIOD/OVF updated this cycle.
- OVF     output  1  last measurement saturated (period ≥ 2^W-1).
- LOCKED  output  1  at least MIN_EDGES edges accepted since reset.

Behaviour:
- Reset values:
  - Synchronous reset, active-high; RESET dominates every other input in the same cycle.
  - PERIOD=0, VALID=0, OVF=0, LOCKED=0, CNT=0, edge count=0, state=IDLE.
  - pulse_d=1 on reset, so a PULSE held high through reset release is not an edge.
- Edge detect:
  - rise = PULSE & ~pulse_d.
  - pulse_d <= PULSE every cycle, regardless of EN.
  - An edge is accepted only if EN=1 in the same cycle. An edge arriving with EN=0 is lost and not deferred.
- States:
  - IDLE:
    - accepted edge -> MEASURE, CNT<=1, no VALID.
  - MEASURE, with EN=1 and no edge:
    - CNT<=CNT+1, saturating at 2^W-1.
  - MEASURE, with EN=1 and accepted edge:
    - Capture PERIOD<=CNT and OVF<=(CNT==2^W-1).
    - VALID<=1 on the next cycle (registered; 1-cycle latency from the edge cycle).
    - CNT<=1; stay in MEASURE.
  - EN=0:
    - CNT, state and outputs hold; VALID deasserts.
- Definition: edges accepted at cycles t0 and t1 with EN continuously high give PERIOD = t1 - t0.
- Saturation:
  - CNT never wraps.
  - A period ≥ 2^W-1 reports PERIOD=2^W-1 with OVF=1.
  - OVF clears on the next non-saturated capture.
- LOCKED:
  - Sticky 1 once the accepted-edge count reaches MIN_EDGES.
  - The edge count saturates at MIN_EDGES.
  - Cleared only by RESET.
- Back-to-back edges: a PULSE pattern of 1,0,1 gives PERIOD=2, which is the minimum measurable period. A single-cycle high PULSE is fine.
- Reset mid-measurement: the partial count is discarded, and the next accepted edge restarts from IDLE. No VALID is produced for the aborted interval.

Optional Feature:
- Macro: PERIOD_METER_SYNC_EN.
- Defined:
  - PULSE first passes through a 2-flop synchronizer (both flops reset to 1) before edge detect.
  - Adds 2 cycles of latency to edge acceptance; measured PERIOD values are unchanged.
  - EN is sampled in the cycle the synchronized edge is seen.
- Undefined:
  - PULSE feeds the edge detector directly and is assumed synchronous to CLOCK.

Decomposition:
- Shared package period_meter_pkg holds:
  - state enum (IDLE, MEASURE),
  - default W and MIN_EDGES,
  - the saturation constant function (2^W-1).
- One sub-module, pulse_edge_det: optional synchronizer plus pulse_d register; outputs rise.
- Counter, capture and lock logic stay in period_meter.

Test Plan:
- Divider loopback: drive PULSE from a 1/1000 divider with EN=1 throughout -> after the 2nd CY, VALID pulses with PERIOD=1000 (W=10), OVF=0, LOCKED=1. Repeats every 1000 cycles.
- Minimum period: PULSE=1,0,1,0,1 from IDLE -> two VALIDs, each PERIOD=2.
- Saturation: edges 1500 cycles apart (W=10) -> PERIOD=1023, OVF=1. A following 400-cycle interval -> PERIOD=400, OVF=0.
- EN gating: edges 100 enabled cycles apart with 50 EN=0 cycles inserted mid-interval -> PERIOD=100. An edge during EN=0 produces no VALID.
- Reset behaviour: PULSE held high across reset release -> no edge accepted. RESET asserted mid-interval then edges 300 apart -> first VALID PERIOD=300, LOCKED rises with it.
- PERIOD_METER_SYNC_EN defined: repeat the divider loopback -> PERIOD=1000, first VALID 2 cycles later than the unsynchronized build.
